// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the fetch FSM state encoding, default widths and the reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        STOPPED = 2'd2
    } fetch_state_t;

    localparam int ADDR_W_DEFAULT    = 7;
    localparam int DATA_W_DEFAULT    = 8;
    localparam int BUF_DEPTH_DEFAULT = 2;
    localparam int CNT_W             = 8;

    localparam logic [ADDR_W_DEFAULT-1:0] PC_RESET = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of control, instruction-memory and execute-side handshake signals.
// The fetch stage uses the master view; its environment uses the slave view.
interface instr_fetch_if import fetch_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    logic              start;
    logic              halt;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;

    logic [CNT_W-1:0]  fetch_cnt;
    logic              stopped;

    modport master (
        input  start, halt, redirect, redirect_addr, mem_rdata, ir_ready,
        output mem_en, mem_addr, ir, ir_pc, ir_valid, fetch_cnt, stopped
    );

    modport slave (
        output start, halt, redirect, redirect_addr, mem_rdata, ir_ready,
        input  mem_en, mem_addr, ir, ir_pc, ir_valid, fetch_cnt, stopped
    );

endinterface

// File: rtl/fetch_buffer.sv
// Small prefetch FIFO of {instruction, pc} pairs with synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_instr,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_instr,
    output logic [ADDR_W-1:0] head_pc,
    output logic              full,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        do_pop  = pop && (count != '0);
        do_push = push && (!full || do_pop);
    end

    // Flush wins over a same-cycle push so stale returning data never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                instr_mem[wr_ptr] <= push_instr;
                pc_mem[wr_ptr]    <= push_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to the synchronous
// instruction memory, buffers returns and hands them to execute.
module instr_fetch import fetch_pkg::*; #(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              epoch;
    logic              inflight;
    logic              inflight_epoch;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              stopped;

    logic [DATA_W-1:0] head_instr;
    logic [ADDR_W-1:0] head_pc;
    logic              buf_full;
    logic [CW-1:0]     buf_count;

    logic              in_fetch;
    logic              head_valid;
    logic              pop;
    logic              push;
    logic              flush;
    logic              issue;
    logic [CW-1:0]     used;

    // A pop this cycle frees a slot, which keeps one issue per cycle going.
    always_comb begin
        in_fetch   = (state == FETCH);
        head_valid = (buf_count != '0);
        pop        = head_valid && bus.ir_ready;
        flush      = in_fetch && (bus.halt || bus.redirect);
        push       = inflight && (inflight_epoch == epoch) && (!buf_full || pop);
        used       = buf_count + CW'(inflight) - CW'(pop);
        issue      = in_fetch && !bus.halt && !bus.redirect && (used < CW'(BUF_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= ADDR_W'(PC_RESET);
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
            fetch_cnt      <= '0;
            stopped        <= 1'b0;
        end else begin
            inflight       <= issue;
            inflight_pc    <= pc;
            inflight_epoch <= epoch;
            if (pop) begin
                fetch_cnt <= sat_inc(fetch_cnt);
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= FETCH;
                        pc    <= ADDR_W'(PC_RESET);
                    end
                end
                FETCH: begin
                    if (bus.halt) begin
                        state    <= STOPPED;
                        stopped  <= 1'b1;
                        inflight <= 1'b0;
                    end else if (bus.redirect) begin
                        pc    <= bus.redirect_addr;
                        epoch <= ~epoch;
                    end else if (issue) begin
                        pc <= pc + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    fetch_buffer #(
        .DEPTH  (BUF_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (bus.mem_rdata),
        .push_pc    (inflight_pc),
        .pop        (pop),
        .flush      (flush),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .full       (buf_full),
        .count      (buf_count)
    );

    assign bus.mem_en    = issue;
    assign bus.mem_addr  = pc;
    assign bus.ir        = head_instr;
    assign bus.ir_pc     = head_pc;
    assign bus.ir_valid  = head_valid;
    assign bus.fetch_cnt = fetch_cnt;
    assign bus.stopped   = stopped;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural synchronous instruction memory.
module tb_instr_fetch;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   issued;
    logic [7:0] mem [128];

    instr_fetch_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    instr_fetch #(.ADDR_W(7), .DATA_W(8), .BUF_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle read latency memory model.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic hl, input logic rd,
                                 input logic [6:0] ra, input logic rdy);
        @(posedge clk);
        #1;
        bus.start         = st;
        bus.halt          = hl;
        bus.redirect      = rd;
        bus.redirect_addr = ra;
        bus.ir_ready      = rdy;
        #2;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.halt = 1'b0; bus.redirect = 1'b0;
        bus.redirect_addr = '0; bus.ir_ready = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h21; mem[1] = 8'h15; mem[2] = 8'hA3; mem[3] = 8'hF0;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.halt = 1'b0; bus.redirect = 1'b0;
        bus.redirect_addr = '0; bus.ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_mem_en",   32'(bus.mem_en),    32'd0);
        checkOutput("rst_ir_valid", 32'(bus.ir_valid),  32'd0);
        checkOutput("rst_stopped",  32'(bus.stopped),   32'd0);
        checkOutput("rst_cnt",      32'(bus.fetch_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
            checkOutput("idle_mem_en", 32'(bus.mem_en), 32'd0);
        end

        // Sequential fetch with ir_ready held high.
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("seq_first_en",   32'(bus.mem_en),   32'd1);
        checkOutput("seq_first_addr", 32'(bus.mem_addr), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("seq_no_bypass",  32'(bus.ir_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
            checkOutput("seq_valid", 32'(bus.ir_valid), 32'd1);
            checkOutput("seq_ir",    32'(bus.ir),       32'(mem[i]));
            checkOutput("seq_ir_pc", 32'(bus.ir_pc),    32'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
        checkOutput("seq_cnt", 32'(bus.fetch_cnt), 32'd4);

        // Asynchronous reset in the middle of a cycle.
        rst_n = 1'b0;
        #1;
        checkOutput("async_mem_en",   32'(bus.mem_en),    32'd0);
        checkOutput("async_mem_addr", 32'(bus.mem_addr),  32'd0);
        checkOutput("async_ir_valid", 32'(bus.ir_valid),  32'd0);
        checkOutput("async_ir",       32'(bus.ir),        32'd0);
        checkOutput("async_ir_pc",    32'(bus.ir_pc),     32'd0);
        checkOutput("async_cnt",      32'(bus.fetch_cnt), 32'd0);
        checkOutput("async_stopped",  32'(bus.stopped),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Backpressure: only two reads may be outstanding or buffered.
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
        issued = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
            issued += int'(bus.mem_en);
            if (i >= 2) begin
                checkOutput("bp_ir_stable", 32'(bus.ir),    32'h21);
                checkOutput("bp_pc_stable", 32'(bus.ir_pc), 32'd0);
            end
        end
        checkOutput("bp_reads", 32'(issued), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("bp_release_ir", 32'(bus.ir),       32'h21);
        checkOutput("bp_resume_en",  32'(bus.mem_en),   32'd1);
        checkOutput("bp_resume_addr",32'(bus.mem_addr), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("bp_next_ir",    32'(bus.ir),       32'h15);
        checkOutput("bp_next_valid", 32'(bus.ir_valid), 32'd1);

        // Redirect while popping pc 2.
        applyStimulus(1'b0, 1'b0, 1'b1, 7'h40, 1'b1);
        checkOutput("rd_pop_pc",  32'(bus.ir_pc),  32'd2);
        checkOutput("rd_pop_ir",  32'(bus.ir),     32'hA3);
        checkOutput("rd_gate_en", 32'(bus.mem_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("rd_flush_valid", 32'(bus.ir_valid), 32'd0);
        checkOutput("rd_target_en",   32'(bus.mem_en),   32'd1);
        checkOutput("rd_target_addr", 32'(bus.mem_addr), 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("rd_gap_valid", 32'(bus.ir_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("rd_tgt_valid", 32'(bus.ir_valid),  32'd1);
        checkOutput("rd_tgt_pc",    32'(bus.ir_pc),     32'h40);
        checkOutput("rd_tgt_ir",    32'(bus.ir),        32'(mem[7'h40]));
        checkOutput("rd_cnt",       32'(bus.fetch_cnt), 32'd3);

        // Halt coinciding with a pop.
        applyStimulus(1'b0, 1'b1, 1'b0, 7'h00, 1'b1);
        checkOutput("halt_pop_pc", 32'(bus.ir_pc), 32'h41);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("halt_stopped", 32'(bus.stopped),   32'd1);
        checkOutput("halt_valid",   32'(bus.ir_valid),  32'd0);
        checkOutput("halt_mem_en",  32'(bus.mem_en),    32'd0);
        checkOutput("halt_cnt",     32'(bus.fetch_cnt), 32'd5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'(i % 2 == 0), 1'b0, 1'b0, 7'h00, 1'b1);
            checkOutput("stop_mem_en", 32'(bus.mem_en), 32'd0);
        end
        checkOutput("stop_sticky", 32'(bus.stopped),   32'd1);
        checkOutput("stop_cnt",    32'(bus.fetch_cnt), 32'd5);

        // Wrap from 0x7F to 0x00, then saturate the counter.
        pulseReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'h7E, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("wrap_addr", 32'(bus.mem_addr), 32'h7E);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
            checkOutput("wrap_pc", 32'(bus.ir_pc), 32'(7'(7'h7E + 7'(i))));
            checkOutput("wrap_ir", 32'(bus.ir),    32'(mem[7'(7'h7E + 7'(i))]));
        end
        checkOutput("wrap_cnt", 32'(bus.fetch_cnt), 32'd2);
        repeat (100) applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("stream_pc",  32'(bus.ir_pc),     32'h64);
        checkOutput("stream_cnt", 32'(bus.fetch_cnt), 32'd102);
        repeat (200) applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("sat_cnt",   32'(bus.fetch_cnt), 32'd255);
        checkOutput("sat_valid", 32'(bus.ir_valid),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of `processor`. It owns the program counter and reads 8-bit instructions from the 128-entry synchronous instruction memory. Instructions pass through a small prefetch buffer and are delivered to the execute stage over a valid/ready handshake. The execute stage can redirect fetch on a taken branch or jump and stop it on HALT. The block also counts delivered instructions, which feeds the cycle/efficiency monitor.

## Interface
Parameters:
- `ADDR_W`, 7, instruction memory address width (128 words)
- `DATA_W`, 8, instruction width
- `BUF_DEPTH`, 2, prefetch buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  level; begin fetching from address 0 when in IDLE
- `halt`  in  1  pulse from execute; stop fetching permanently
- `redirect`  in  1  pulse; taken branch/jump
- `redirect_addr`  in  ADDR_W  target of redirect
- `mem_en`  out  1  instruction memory read enable
- `mem_addr`  out  ADDR_W  read address
- `mem_rdata`  in  DATA_W  read data, valid 1 cycle after `mem_en`
- `ir`  out  DATA_W  instruction at buffer head
- `ir_pc`  out  ADDR_W  address of `ir`
- `ir_valid`  out  1  `ir`/`ir_pc` valid
- `ir_ready`  in  1  execute accepts head
- `fetch_cnt`  out  8  accepted instructions, saturating
- `stopped`  out  1  high in STOPPED

## Operation
- States: IDLE → FETCH on `start`=1 (pc←0). FETCH → STOPPED on `halt`. STOPPED is sticky; only `rst_n` exits it.
- Issue rule in FETCH: `mem_en`=1 when buffer occupancy + in-flight reads < BUF_DEPTH and there is no `redirect`/`halt` this cycle. `mem_addr`=pc. pc increments on each issue and wraps from 127 to 0.
- The returning read writes {`mem_rdata`, issued address} into the buffer, but only if its epoch bit matches the current epoch.
- `redirect`: flush buffer, toggle epoch (in-flight read discarded), pc←`redirect_addr`. Issue resumes the next cycle.
- `halt`: flush buffer, drop in-flight read, `mem_en`=0 from the next cycle onward.
- Priority: `halt` > `redirect` > issue. A pop (`ir_valid`&&`ir_ready`) in the same cycle as `redirect` or `halt` still completes and is counted.
- `fetch_cnt` increments on every pop and saturates at 255.
- `start` is ignored outside IDLE. Deasserting `start` in FETCH has no effect.

## Timing
- Reset values: state IDLE, pc 0, `mem_en` 0, `mem_addr` 0, `ir` 0, `ir_pc` 0, `ir_valid` 0, `fetch_cnt` 0, `stopped` 0, epoch 0, buffer empty.
- Start latency: `start` sampled at edge k → `mem_en`=1 with addr 0 in cycle k+1 → data written at edge k+2 → `ir_valid`=1 in cycle k+2. The buffer has no bypass.
- With `ir_ready` held high, throughput is one instruction per cycle after the first.
- With `ir_ready`=0, the buffer fills to BUF_DEPTH and `mem_en` drops. `ir`/`ir_pc` stay stable while `ir_valid`&&!`ir_ready`.
- Redirect at edge r: `ir_valid`=0 in cycle r. `mem_en` with `redirect_addr` in cycle r+1. Target instruction valid in cycle r+2.
- Halt at edge h: `ir_valid`=0, `mem_en`=0, `stopped`=1 from cycle h onward.
- Asynchronous `rst_n` assertion mid-operation returns all state to reset values immediately. Outstanding read data is ignored.

## Structure
- Package `fetch_pkg`: state enum (IDLE, FETCH, STOPPED), `ADDR_W`/`DATA_W` defaults, `PC_RESET`=0.
- Sub-module `fetch_buffer`: BUF_DEPTH-entry FIFO of {instr, pc} with push, pop, flush, full and count outputs. The top level holds the FSM, pc, epoch, credit logic and counter.

## Test plan
- Reset: drive `rst_n`=0 mid-stream → all outputs at reset values the same cycle. Release, no `start` → `mem_en` stays 0.
- Sequential fetch: memory[0..3]=0x21,0x15,0xA3,0xF0; `start`; `ir_ready`=1 → `ir` 0x21,0x15,0xA3,0xF0 on consecutive cycles starting 2 cycles after `start`; `ir_pc` 0..3; `fetch_cnt`=4.
- Backpressure: `ir_ready`=0 for 6 cycles → `mem_en` issues exactly 2 reads then stays 0; `ir`=0x21 stable; release → 0x15 follows with no gap.
- Redirect: at pop of pc 2, `redirect`=1 with addr 0x40 → no instruction from pc 3 is ever delivered; next `ir_pc`=0x40 two cycles later.
- Halt with simultaneous pop: `halt` and pop in the same cycle → `fetch_cnt` increments once; `stopped`=1; `mem_en`=0 thereafter; `start` pulses ignored.
- Wrap and saturation: redirect to 0x7E, free-run → `ir_pc` 0x7E,0x7F,0x00. Run 300 pops → `fetch_cnt`=255.
